hazard_ctrl: RTL
================

Name: hazard_ctrl

Overview:
- Pipeline control block for the 5-stage CPU: fetch, decode, execute, memory, writeback.
- Sits directly upstream of the stage pipeline registers (flopenrc instances F/D, D/E, E/M, M/W).
- Produces their enable (as active-high stall, en = ~stall) and clear (flush) inputs, plus execute-stage forwarding selects.
- Owns the multi-cycle memory-wait state machine, including the timeout watchdog.

Parameters:
- REG_AW, 5, register-index width.
- MEM_TIMEOUT, 16, max wait cycles for mem_ready before abort (≥2).
- CNT_W, 32, performance counter width.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high.
- rs1_d, rs2_d  in  REG_AW  source registers in decode.
- rs1_e, rs2_e, rd_e  in  REG_AW  execute-stage register indices.
- rd_m, rd_w  in  REG_AW  destination registers in memory and writeback.
- regwrite_m, regwrite_w  in  1  destination write enables.
- memread_e  in  1  execute holds a load.
- pcsrc_e  in  1  taken branch/jump resolved in execute.
- mem_req_m  in  1  memory stage has an active access.
- mem_ready  in  1  data memory completes access this cycle.
- stall_f, stall_d, stall_e, stall_m  out  1  hold stage register (drives en = ~stall).
- flush_d, flush_e, flush_w  out  1  clear stage register to bubble.
- fwd_a_e, fwd_b_e  out  2  operand select: 00 register file, 01 from W, 10 from M.
- mem_err  out  1  sticky timeout flag.
- stall_cnt, flush_cnt  out  CNT_W  performance counters.

Behaviour:
- Reset: FSM → IDLE, wait counter 0, mem_err 0, counters 0. All stall/flush outputs are combinational and read 0 while reset is high.
- Forwarding (combinational):
  - fwd_a_e = 10 if regwrite_m & rd_m==rs1_e & rs1_e!=0.
  - else 01 if regwrite_w & rd_w==rs1_e & rs1_e!=0.
  - else 00. fwd_b_e is identical with rs2_e. M has priority over W.
- Load-use: lw_hz = memread_e & rd_e!=0 & (rd_e==rs1_d | rd_e==rs2_d).
- Memory FSM states: IDLE, WAIT.
  - IDLE → WAIT when mem_req_m & ~mem_ready; counter loads 1.
  - WAIT → IDLE when mem_ready.
  - WAIT → IDLE when counter==MEM_TIMEOUT: one-cycle abort, mem_err set (sticky until reset), counter cleared.
  - Otherwise the counter increments each WAIT cycle.
  - mem_req_m & mem_ready in IDLE is a zero-wait access; stay IDLE, no stall.
- mem_stall = mem_req_m & ~mem_ready & ~abort. Latency: asserted the same cycle the request is seen. Released combinationally in the cycle mem_ready (or abort) occurs.
- Priority, first match wins:
  - mem_stall: stall_f/d/e/m=1, flush_w=1, all other flushes 0. Branch and load-use are ignored because E is frozen.
  - pcsrc_e: flush_d=1, flush_e=1, no stalls. This suppresses lw_hz because the younger instruction is squashed.
  - lw_hz: stall_f=1, stall_d=1, flush_e=1.
  - none: all 0.
- Reset mid-WAIT: next cycle IDLE, stalls drop, mem_err cleared.
- mem_req_m dropping during WAIT (upstream abort): return to IDLE next cycle, no error.

Optional Feature:
- HAZARD_PERF_CNT_EN defined:
  - stall_cnt increments every cycle any stall_* is 1.
  - flush_cnt increments every cycle flush_d or flush_e is 1.
  - Both wrap at 2^CNT_W and clear on reset.
- Undefined: both counters are tied to 0 and no counter flops are built.

Decomposition:
- Shared package cpu_pkg holds:
  - fwd_sel_t enum: FWD_RF=2'b00, FWD_W=2'b01, FWD_M=2'b10.
  - mem_state_t enum: IDLE, WAIT.
  - Default REG_AW.
- One natural sub-module: mem_wait_fsm, containing the FSM, wait counter, abort and mem_err. hazard_ctrl keeps forwarding, priority logic and counters.

Test Plan:
- Forwarding: regwrite_m=1, rd_m=5, regwrite_w=1, rd_w=5, rs1_e=5 → fwd_a_e=10. Then rd_m=0 with rs1_e=0 → fwd_a_e=00.
- Load-use: memread_e=1, rd_e=7, rs2_d=7 → stall_f=stall_d=flush_e=1 for exactly that cycle. Same stimulus plus pcsrc_e=1 → only flush_d=flush_e=1.
- Memory wait: mem_req_m=1, mem_ready low 3 cycles then high → stall_f/d/e/m and flush_w high 3 cycles, 0 on the ready cycle, FSM back to IDLE, mem_err=0.
- Timeout: mem_req_m=1, mem_ready never → stalls held MEM_TIMEOUT cycles, abort cycle releases, mem_err=1 stays high; reset clears it.
- Branch during memory stall: pcsrc_e=1 while mem_stall → flush_d=flush_e=0, stalls=1. After release with pcsrc_e still 1 → flush_d=flush_e=1.
- HAZARD_PERF_CNT_EN: 3-cycle mem stall plus 1 branch flush → stall_cnt=3, flush_cnt=1. Without the macro both read 0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared types for the CPU pipeline control: forwarding selects, memory-wait FSM states,
// and the default register-index width.
package cpu_pkg;

  localparam int unsigned DEFAULT_REG_AW = 5;

  typedef enum logic [1:0] {
    FWD_RF = 2'b00,
    FWD_W  = 2'b01,
    FWD_M  = 2'b10
  } fwd_sel_t;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } mem_state_t;

endpackage

// File: rtl/mem_wait_fsm.sv
// Multi-cycle data-memory wait tracker: raises mem_stall while an access is outstanding and
// aborts it with a sticky mem_err once the wait counter reaches MEM_TIMEOUT.
module mem_wait_fsm
  import cpu_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic mem_req_m,
  input  logic mem_ready,
  output logic mem_stall,
  output logic mem_err
);

  localparam int unsigned CntW = $clog2(MEM_TIMEOUT + 1);

  mem_state_t      state;
  logic [CntW-1:0] wait_cnt;
  logic            abort;

  // A ready on the timeout cycle still completes the access rather than aborting it.
  assign abort     = (state == WAIT) & mem_req_m & ~mem_ready &
                     (wait_cnt == CntW'(MEM_TIMEOUT));
  assign mem_stall = mem_req_m & ~mem_ready & ~abort;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      wait_cnt <= '0;
      mem_err  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (mem_req_m && !mem_ready) begin
            state    <= WAIT;
            wait_cnt <= CntW'(1);
          end
        end
        WAIT: begin
          if (!mem_req_m || mem_ready) begin
            state    <= IDLE;
            wait_cnt <= '0;
          end else if (abort) begin
            state    <= IDLE;
            wait_cnt <= '0;
            mem_err  <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + CntW'(1);
          end
        end
        default: begin
          state    <= IDLE;
          wait_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// 5-stage pipeline hazard control: forwarding selects, stall/flush priority and the memory-wait
// FSM. Define HAZARD_PERF_CNT_EN to build the stall/flush performance counters.
module hazard_ctrl
  import cpu_pkg::*;
#(
  parameter int unsigned REG_AW      = DEFAULT_REG_AW,
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [REG_AW-1:0] rs1_d,
  input  logic [REG_AW-1:0] rs2_d,
  input  logic [REG_AW-1:0] rs1_e,
  input  logic [REG_AW-1:0] rs2_e,
  input  logic [REG_AW-1:0] rd_e,
  input  logic [REG_AW-1:0] rd_m,
  input  logic [REG_AW-1:0] rd_w,
  input  logic              regwrite_m,
  input  logic              regwrite_w,
  input  logic              memread_e,
  input  logic              pcsrc_e,
  input  logic              mem_req_m,
  input  logic              mem_ready,
  output logic              stall_f,
  output logic              stall_d,
  output logic              stall_e,
  output logic              stall_m,
  output logic              flush_d,
  output logic              flush_e,
  output logic              flush_w,
  output logic [1:0]        fwd_a_e,
  output logic [1:0]        fwd_b_e,
  output logic              mem_err,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  logic mem_stall;
  logic lw_hz;

  mem_wait_fsm #(
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) u_mem_wait_fsm (
    .clk      (clk),
    .reset    (reset),
    .mem_req_m(mem_req_m),
    .mem_ready(mem_ready),
    .mem_stall(mem_stall),
    .mem_err  (mem_err)
  );

  // M is the younger producer, so it wins over W; x0 is never forwarded.
  function automatic fwd_sel_t fwd_pick(input logic [REG_AW-1:0] rs);
    if (regwrite_m && (rd_m == rs) && (rs != '0)) return FWD_M;
    if (regwrite_w && (rd_w == rs) && (rs != '0)) return FWD_W;
    return FWD_RF;
  endfunction

  assign fwd_a_e = fwd_pick(rs1_e);
  assign fwd_b_e = fwd_pick(rs2_e);

  assign lw_hz = memread_e & (rd_e != '0) & ((rd_e == rs1_d) | (rd_e == rs2_d));

  always_comb begin
    stall_f = 1'b0;
    stall_d = 1'b0;
    stall_e = 1'b0;
    stall_m = 1'b0;
    flush_d = 1'b0;
    flush_e = 1'b0;
    flush_w = 1'b0;
    if (!reset) begin
      if (mem_stall) begin
        // E is frozen, so a pending branch or load-use is resolved after release.
        stall_f = 1'b1;
        stall_d = 1'b1;
        stall_e = 1'b1;
        stall_m = 1'b1;
        flush_w = 1'b1;
      end else if (pcsrc_e) begin
        flush_d = 1'b1;
        flush_e = 1'b1;
      end else if (lw_hz) begin
        stall_f = 1'b1;
        stall_d = 1'b1;
        flush_e = 1'b1;
      end
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] flush_cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (stall_f || stall_d || stall_e || stall_m) stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      if (flush_d || flush_e) flush_cnt_q <= flush_cnt_q + CNT_W'(1);
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule
